// File: rtl/inst_prefetch_queue_if.sv
// Byte-interface bundle between the prefetch queue, the BIU fetch port and the decoder.
// The slave side is the queue itself; the master side is its environment.
interface inst_prefetch_queue_if #(parameter int DEPTH = 6);
  logic                 iFlush;
  logic [19:0]          iFlushAddr;
  logic                 oFetchReq;
  logic [19:0]          oFetchAddr;
  logic                 iFetchAck;
  logic [15:0]          iFetchData;
  logic [8*DEPTH-1:0]   oWindow;
  logic [2:0]           oCount;
  logic [19:0]          oHeadAddr;
  logic                 iPop;
  logic [2:0]           iPopCnt;

  modport slave (
    input  iFlush, iFlushAddr, iFetchAck, iFetchData, iPop, iPopCnt,
    output oFetchReq, oFetchAddr, oWindow, oCount, oHeadAddr
  );
  modport master (
    output iFlush, iFlushAddr, iFetchAck, iFetchData, iPop, iPopCnt,
    input  oFetchReq, oFetchAddr, oWindow, oCount, oHeadAddr
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// 8086-style byte prefetch queue: fetches 16-bit words from the BIU and
// presents the oldest bytes to the decoder, retiring them on pop.

// One byte slot of the queue: next value is the byte shifted in from
// position IDX+popEff, overridden by freshly fetched bytes landing here.
module ipqSlot #(
  parameter int DEPTH = 6,
  parameter int IDX   = 0
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iFlush,
  input  logic [DEPTH-1:0][7:0] iWin,
  input  logic [2:0]            iPopEff,
  input  logic [2:0]            iBase,
  input  logic                  iXfer,
  input  logic                  iOdd,
  input  logic [15:0]           iData,
  output logic [7:0]            oByte
);
  localparam logic [3:0] POS = 4'(IDX);

  logic [7:0] nxt;

  always_comb begin
    nxt = '0;
    for (int s = 0; s < DEPTH; s++)
      if (4'(s) == POS + {1'b0, iPopEff}) nxt = iWin[s];
    if (iXfer) begin
      if ({1'b0, iBase} == POS)
        nxt = iOdd ? iData[15:8] : iData[7:0];
      else if (!iOdd && ({1'b0, iBase} + 4'd1) == POS)
        nxt = iData[15:8];
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)     oByte <= '0;
    else if (iFlush) oByte <= '0;
    else             oByte <= nxt;
  end
endmodule

module inst_prefetch_queue #(
  parameter int          DEPTH      = 6,
  parameter logic [19:0] RESET_ADDR = 20'hFFFF0
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  inst_prefetch_queue_if.slave  pq
);
  logic [DEPTH-1:0][7:0] win;
  logic [2:0]            count, popEff, base, appended, countNext;
  logic [19:0]           head, fetchAddr;
  logic                  req, xfer;

  // Pop is applied first; new bytes land right behind the survivors.
  always_comb begin
    xfer     = req & pq.iFetchAck;
    popEff   = '0;
    if (pq.iPop) popEff = (pq.iPopCnt < count) ? pq.iPopCnt : count;
    base      = count - popEff;
    appended  = xfer ? (fetchAddr[0] ? 3'd1 : 3'd2) : 3'd0;
    countNext = base + appended;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gSlot
    ipqSlot #(.DEPTH(DEPTH), .IDX(i)) uSlot (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iFlush  (pq.iFlush),
      .iWin    (win),
      .iPopEff (popEff),
      .iBase   (base),
      .iXfer   (xfer),
      .iOdd    (fetchAddr[0]),
      .iData   (pq.iFetchData),
      .oByte   (win[i])
    );
  end

  // Request only with room for a full word and never back-to-back, so at
  // most one fetch is in flight and the queue cannot overflow.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      count     <= '0;
      head      <= RESET_ADDR;
      fetchAddr <= RESET_ADDR;
      req       <= 1'b0;
    end else if (pq.iFlush) begin
      count     <= '0;
      head      <= pq.iFlushAddr;
      fetchAddr <= pq.iFlushAddr;
      req       <= 1'b1;
    end else begin
      count <= countNext;
      head  <= head + {17'd0, popEff};
      if (xfer) fetchAddr <= fetchAddr + (fetchAddr[0] ? 20'd1 : 20'd2);
      req   <= !xfer && (countNext <= 3'(DEPTH - 2));
    end
  end

  assign pq.oWindow    = win;
  assign pq.oCount     = count;
  assign pq.oHeadAddr  = head;
  assign pq.oFetchAddr = fetchAddr;
  assign pq.oFetchReq  = req;
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios with literal expectations,
// then random traffic checked every cycle against a byte-queue model.
module tb_inst_prefetch_queue;
  localparam int          DEPTH = 6;
  localparam logic [19:0] RADDR = 20'hFFFF0;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  inst_prefetch_queue_if #(.DEPTH(DEPTH)) pq ();

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(RADDR)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .pq     (pq)
  );

  int nChk = 0;
  int nFail = 0;
  bit memMode = 0;

  // Model: plain byte FIFO plus the two addresses and the request flag.
  logic [7:0]  mq[$];
  logic [19:0] mHead, mFetch;
  bit          mReq;

  function automatic logic [7:0] memByte(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'hA5;
  endfunction

  function automatic logic [15:0] memWord(input logic [19:0] a);
    logic [19:0] ev;
    ev = {a[19:1], 1'b0};
    return {memByte(ev + 20'd1), memByte(ev)};
  endfunction

  function automatic void modelReset();
    mq.delete();
    mHead  = RADDR;
    mFetch = RADDR;
    mReq   = 0;
  endfunction

  function automatic void modelStep(input bit fl, input logic [19:0] fa, input bit ack,
                                    input logic [15:0] d, input bit pop, input logic [2:0] pc);
    int  pe;
    bit  x;
    if (fl) begin
      mq.delete();
      mHead  = fa;
      mFetch = fa;
      mReq   = 1;
      return;
    end
    x  = mReq && ack;
    pe = 0;
    if (pop) pe = (int'(pc) < mq.size()) ? int'(pc) : mq.size();
    repeat (pe) void'(mq.pop_front());
    mHead = mHead + 20'(pe);
    if (x) begin
      if (!mFetch[0]) begin
        mq.push_back(d[7:0]);
        mq.push_back(d[15:8]);
        mFetch = mFetch + 20'd2;
      end else begin
        mq.push_back(d[15:8]);
        mFetch = mFetch + 20'd1;
      end
    end
    mReq = !x && (mq.size() <= DEPTH - 2);
  endfunction

  function automatic logic [8*DEPTH-1:0] expWin();
    logic [8*DEPTH-1:0] w;
    w = '0;
    foreach (mq[k]) w[8*k +: 8] = mq[k];
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    chk("count",     64'(pq.oCount),     64'(mq.size()));
    chk("window",    64'(pq.oWindow),    64'(expWin()));
    chk("headAddr",  64'(pq.oHeadAddr),  64'(mHead));
    chk("fetchAddr", 64'(pq.oFetchAddr), 64'(mFetch));
    chk("fetchReq",  64'(pq.oFetchReq),  64'(mReq));
    if (memMode)
      for (int k = 0; k < int'(pq.oCount) && k < DEPTH; k++)
        chk("byteAtAddr", 64'(pq.oWindow[8*k +: 8]), 64'(memByte(pq.oHeadAddr + 20'(k))));
  endtask

  // Drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic step(input bit fl, input logic [19:0] fa, input bit ack,
                      input logic [15:0] d, input bit pop, input logic [2:0] pc);
    pq.iFlush = fl; pq.iFlushAddr = fa; pq.iFetchAck = ack;
    pq.iFetchData = d; pq.iPop = pop; pq.iPopCnt = pc;
    @(posedge iClk);
    modelStep(fl, fa, ack, d, pop, pc);
    @(negedge iClk);
    compareAll();
  endtask

  task automatic idle();
    step(0, 20'd0, 0, 16'd0, 0, 3'd0);
  endtask

  task automatic fetchWord(input logic [15:0] d);
    int n = 0;
    while (!mReq && n < 8) begin idle(); n++; end
    if (!mReq) chk("reqTimeout", 64'(pq.oFetchReq), 64'd1);
    step(0, 20'd0, 1, d, 0, 3'd0);
  endtask

  initial begin
    pq.iFlush = 0; pq.iFlushAddr = '0; pq.iFetchAck = 0;
    pq.iFetchData = '0; pq.iPop = 0; pq.iPopCnt = '0;
    modelReset();
    @(negedge iClk); @(negedge iClk);
    compareAll();
    chk("rstWindow", 64'(pq.oWindow), 64'd0);
    chk("rstHead",   64'(pq.oHeadAddr), 64'h0FFFF0);
    iRst_n = 1;
    idle();
    chk("reqAfterRst", 64'(pq.oFetchReq), 64'd1);

    // Fill from reset address.
    fetchWord(16'h2211); fetchWord(16'h4433); fetchWord(16'h6655);
    chk("fillCount",  64'(pq.oCount),     64'd6);
    chk("fillWindow", 64'(pq.oWindow),    64'h665544332211);
    chk("fillReq",    64'(pq.oFetchReq),  64'd0);
    chk("fillAddr",   64'(pq.oFetchAddr), 64'h0FFFF6);
    repeat (3) idle();
    chk("fullStaysOff", 64'(pq.oFetchReq), 64'd0);

    // Odd flush target keeps only the high byte.
    step(1, 20'h01235, 0, 16'd0, 0, 3'd0);
    fetchWord(16'hAB00);
    chk("oddCount", 64'(pq.oCount),         64'd1);
    chk("oddByte",  64'(pq.oWindow[7:0]),   64'hAB);
    chk("oddHead",  64'(pq.oHeadAddr),      64'h01235);
    chk("oddNext",  64'(pq.oFetchAddr),     64'h01236);

    // Pop 3 and append in the same cycle.
    step(1, 20'h00100, 0, 16'd0, 0, 3'd0);
    fetchWord(16'h2211); fetchWord(16'h4433);
    idle();
    step(0, 20'd0, 1, 16'h6655, 1, 3'd3);
    chk("popAppCount", 64'(pq.oCount),    64'd3);
    chk("popAppWin",   64'(pq.oWindow),   64'h000000665544);
    chk("popAppHead",  64'(pq.oHeadAddr), 64'h00103);

    // Over-pop clamps.
    step(1, 20'h00200, 0, 16'd0, 0, 3'd0);
    fetchWord(16'hBBAA);
    step(0, 20'd0, 0, 16'd0, 1, 3'd5);
    chk("overPopCount", 64'(pq.oCount),    64'd0);
    chk("overPopHead",  64'(pq.oHeadAddr), 64'h00202);

    // 20-bit wrap.
    step(1, 20'hFFFFE, 0, 16'd0, 0, 3'd0);
    fetchWord(16'h2211);
    chk("wrapFetch", 64'(pq.oFetchAddr), 64'h00000);
    fetchWord(16'h4433);
    step(0, 20'd0, 0, 16'd0, 1, 3'd3);
    chk("wrapHead",  64'(pq.oHeadAddr), 64'h00001);
    chk("wrapByte",  64'(pq.oWindow[7:0]), 64'h44);

    // Flush beats a simultaneous ack and pop.
    if (!mReq) idle();
    step(1, 20'h0ABCD, 1, 16'h7777, 1, 3'd2);
    chk("flushCount",  64'(pq.oCount),     64'd0);
    chk("flushWindow", 64'(pq.oWindow),    64'd0);
    chk("flushReq",    64'(pq.oFetchReq),  64'd1);
    chk("flushAddr",   64'(pq.oFetchAddr), 64'h0ABCD);

    // Asynchronous reset while a request is being acked.
    pq.iFetchAck = 1; pq.iFetchData = 16'h9988;
    #2 iRst_n = 0;
    #1;
    chk("asyncReq",   64'(pq.oFetchReq),  64'd0);
    chk("asyncAddr",  64'(pq.oFetchAddr), 64'h0FFFF0);
    chk("asyncHead",  64'(pq.oHeadAddr),  64'h0FFFF0);
    chk("asyncCount", 64'(pq.oCount),     64'd0);
    modelReset();
    @(negedge iClk);
    compareAll();
    iRst_n = 1;
    pq.iFetchAck = 0;

    // Random traffic against the model; data is a function of address.
    memMode = 1;
    step(1, 20'hFFFF9, 0, 16'd0, 0, 3'd0);
    for (int c = 0; c < 3000; c++) begin
      bit          fl;
      logic [19:0] fa;
      fl = ($urandom_range(0, 31) == 0);
      fa = ($urandom_range(0, 3) == 0) ? (20'hFFFF8 + 20'($urandom_range(0, 7))) : 20'($urandom);
      step(fl, fa, 1'($urandom_range(0, 1)), memWord(mFetch),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
